pcm_fir_decim2: RTL
===================

// Module: pcm_fir_decim2
// PURPOSE
//  Compensating FIR + decimate-by-2 stage sitting directly downstream of the CIC3 PDM decimator.
//  Consumes 16-bit signed PCM samples with a valid pulse; computes one TAPS-tap FIR output every
//  second input sample, using a single time-multiplexed MAC. Coefficients are run-time writable;
//  output is rounded and saturated to 16 bits.
// PARAMETERS
//  TAPS        16   number of FIR taps; 2..32; must be < input sample spacing minus 2 clocks
//  DATA_W      16   PCM input/output width, signed
//  COEF_W      16   coefficient width, signed Q1.(COEF_W-1)
//  ACC_W       40   accumulator width, signed; >= DATA_W+COEF_W+clog2(TAPS)
// PORTS
//  clk         in   1       single clock for the whole block
//  rst_n       in   1       synchronous reset, active low
//  enable      in   1       low: in_valid ignored, decimation phase held at 0
//  in_sample   in   DATA_W  PCM sample, signed
//  in_valid    in   1       one-cycle strobe, in_sample valid
//  coef_we     in   1       coefficient write strobe
//  coef_addr   in   5       tap index 0..TAPS-1 (0 = newest sample)
//  coef_data   in   COEF_W  coefficient value, signed
//  out_sample  out  DATA_W  filtered, decimated sample, signed
//  out_valid   out  1       one-cycle strobe, out_sample valid
//  busy        out  1       high while MAC sequence in progress
//  overrun     out  1       sticky: trigger arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_sample=0, out_valid=0, busy=0, overrun=0, phase=0, write ptr=0,
//   all sample-buffer entries=0, coef[0]=0x7FFF, coef[1..TAPS-1]=0 (pass-through default).
//  Reset mid-sequence aborts the MAC; no out_valid is produced for the aborted sample.
//  Sample buffer: circular, TAPS entries; every accepted in_valid (enable=1) writes in_sample at
//   write ptr and advances it, wrapping TAPS-1 -> 0. Writes occur in every state.
//  Phase toggles on each accepted sample; a sample accepted with phase=1 is a trigger.
//  FSM IDLE -> MAC -> ROUND -> IDLE:
//   IDLE : trigger -> MAC, k=0, acc=0.
//   MAC  : each clock acc += x[newest-k] * coef[k] (full-precision signed product, sign-extended
//          to ACC_W); after k=TAPS-1 -> ROUND. newest = sample written by the trigger.
//   ROUND: out_sample = sat(( acc + 2^(COEF_W-2) ) >>> (COEF_W-1)) to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
//          out_valid=1 for exactly this one cycle; -> IDLE.
//  Latency: trigger sampled at edge E0; out_valid high during cycle after edge E(TAPS+1).
//  busy = (state != IDLE).
//  Trigger while busy: sample still written, phase still toggles, overrun set, no new sequence;
//   current sequence completes normally (buffer index math uses the latched newest pointer).
//  Non-trigger sample arriving during MAC: written normally; must not corrupt taps in use
//   (TAPS constraint guarantees the oldest in-use entry is not overwritten).
//  coef_we: accepted only in IDLE and when coef_addr < TAPS; otherwise dropped, no side effects.
//   coef_we and trigger on same IDLE edge: coefficient write lands first; sequence uses new value.
//  enable=0: in_valid ignored, phase forced to 0; in-progress sequence still completes.
// STRUCTURE
//  pdm_pkg.vh: DATA_W/COEF_W/ACC_W defaults, FSM state encodings (IDLE/MAC/ROUND), default
//   coefficient constant 0x7FFF, rounding/saturation macro shared with other PCM stages.
//  Sub-module pcm_ring_buf: TAPS x DATA_W circular sample store, one write port, one indexed
//   read port (newest-relative offset), synchronous reset clearing all entries.
//  MAC, FSM, coefficient file and round/saturate stay in pcm_fir_decim2.
// TESTING
//  1 Reset defaults, feed 1000,2000,3000,4000 -> out_valid twice, out_sample 2000 then 4000;
//    each out_valid exactly TAPS+1 edges after the 2nd/4th in_valid.
//  2 Write coef[0..3]=0x2000, rest 0; constant input 4000 -> settled outputs 4000 (0.25*4*4000).
//  3 All coef 0x7FFF, constant input 32767 -> out_sample saturates to 32767; input -32768 ->
//    -32768; no wrap.
//  4 Issue trigger while busy (inputs 2 clocks apart) -> overrun=1 sticky, only one out_valid;
//    next properly spaced pair produces correct output.
//  5 coef_we during MAC -> dropped (readback via impulse response unchanged); coef_addr=TAPS
//    in IDLE -> dropped.
//  6 rst_n low mid-MAC -> no out_valid, busy=0 next cycle; enable=0 for 3 in_valids -> no
//    output, phase 0; impulse 16384 after re-enable -> out_sample sequence equals coef[k]/2.

Source files
------------

// File: rtl/pcm_fir_decim2_pkg.sv
// Shared definitions for the compensating FIR / decimate-by-2 stage.
package pcm_fir_decim2_pkg;

    localparam int TAPS_DEF    = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int COEF_W_DEF  = 16;
    localparam int ACC_W_DEF   = 40;
    localparam int COEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } firState_e;

endpackage

// File: rtl/pcm_ring_buf.sv
// Circular TAPS-deep sample store: one write port, one newest-relative read port.
module pcm_ring_buf
    import pcm_fir_decim2_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrEn_i,
    input  logic signed [DATA_W-1:0] wrData_i,
    output logic        [IDX_W-1:0]  wrPtr_o,
    input  logic        [IDX_W-1:0]  rdBase_i,
    input  logic        [IDX_W-1:0]  rdOffset_i,
    output logic signed [DATA_W-1:0] rdData_o
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] DEPTH_MOD = IDX_W'(TAPS);

    logic signed [DATA_W-1:0] mem_q [TAPS];
    logic        [IDX_W-1:0]  wrPtr_q;
    logic        [IDX_W-1:0]  wrPtr_d;
    logic        [IDX_W-1:0]  rdIdx;

    // Advance the write pointer on each write, wrapping at the last entry.
    always_comb begin
        wrPtr_d = wrPtr_q;
        if (wrEn_i) begin
            wrPtr_d = (wrPtr_q == LAST_IDX) ? '0 : wrPtr_q + IDX_W'(1);
        end
    end

    // Store the incoming sample; reset clears every entry so the filter starts from silence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            if (wrEn_i) begin
                mem_q[wrPtr_q] <= wrData_i;
            end
        end
    end

    // Map (newest - offset) back into the ring, modulo TAPS.
    always_comb begin
        if (rdBase_i >= rdOffset_i) begin
            rdIdx = rdBase_i - rdOffset_i;
        end else begin
            rdIdx = rdBase_i + DEPTH_MOD - rdOffset_i;
        end
    end

    assign rdData_o = mem_q[rdIdx];
    assign wrPtr_o  = wrPtr_q;

endmodule

// File: rtl/pcm_fir_decim2.sv
// Compensating FIR with decimate-by-2: one time-multiplexed MAC, writable coefficients,
// rounded and saturated output.
module pcm_fir_decim2
    import pcm_fir_decim2_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_W-1:0]     in_sample,
    input  logic                         in_valid,
    input  logic                         coef_we,
    input  logic [COEF_ADDR_W-1:0]       coef_addr,
    input  logic signed [COEF_W-1:0]     coef_data,
    output logic signed [DATA_W-1:0]     out_sample,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [IDX_W-1:0]         LAST_TAP    = IDX_W'(TAPS - 1);
    localparam logic signed [COEF_W-1:0] COEF_UNITY  = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ROUND_BIAS  = {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX     = ACC_W'(DATA_MAX);
    localparam logic signed [ACC_W-1:0]  SAT_MIN     = ACC_W'(DATA_MIN);

    firState_e                  state_q, state_d;
    logic        [IDX_W-1:0]    tap_q, tap_d;
    logic        [IDX_W-1:0]    newest_q, newest_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       phase_q, phase_d;
    logic                       overrun_q, overrun_d;
    logic                       outValid_q, outValid_d;
    logic signed [DATA_W-1:0]   outSample_q, outSample_d;
    logic signed [COEF_W-1:0]   coef_q [TAPS];

    logic                       accepted;
    logic                       trigger;
    logic                       coefWrite;
    logic        [IDX_W-1:0]    wrPtr;
    logic signed [DATA_W-1:0]   tapSample;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    productExt;
    logic signed [ACC_W-1:0]    rounded;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   saturated;

    assign accepted  = enable & in_valid;
    assign trigger   = accepted & phase_q;
    assign coefWrite = coef_we && (state_q == ST_IDLE) && (32'(coef_addr) < TAPS);

    pcm_ring_buf #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ringBuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrEn_i     (accepted),
        .wrData_i   (in_sample),
        .wrPtr_o    (wrPtr),
        .rdBase_i   (newest_q),
        .rdOffset_i (tap_q),
        .rdData_o   (tapSample)
    );

    // Full-precision tap product, then round-half-up and clamp the accumulator to the output range.
    always_comb begin
        product    = PROD_W'(tapSample) * PROD_W'(coef_q[tap_q]);
        productExt = ACC_W'(product);
        rounded    = acc_q + ROUND_BIAS;
        shifted    = rounded >>> (COEF_W - 1);
        if (shifted > SAT_MAX) begin
            saturated = DATA_MAX;
        end else if (shifted < SAT_MIN) begin
            saturated = DATA_MIN;
        end else begin
            saturated = shifted[DATA_W-1:0];
        end
    end

    // Sequencer: latch the trigger sample's slot, run one tap per clock, then emit one rounded result.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        newest_d    = newest_q;
        acc_d       = acc_q;
        outValid_d  = 1'b0;
        outSample_d = outSample_q;
        overrun_d   = overrun_q;
        phase_d     = phase_q;

        if (!enable) begin
            phase_d = 1'b0;
        end else if (in_valid) begin
            phase_d = ~phase_q;
        end

        if (trigger && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d  = ST_MAC;
                    tap_d    = '0;
                    acc_d    = '0;
                    newest_d = wrPtr;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + productExt;
                if (tap_q == LAST_TAP) begin
                    state_d = ST_ROUND;
                end else begin
                    tap_d = tap_q + IDX_W'(1);
                end
            end
            ST_ROUND: begin
                outSample_d = saturated;
                outValid_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            newest_q    <= '0;
            acc_q       <= '0;
            phase_q     <= 1'b0;
            overrun_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outSample_q <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            newest_q    <= newest_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            overrun_q   <= overrun_d;
            outValid_q  <= outValid_d;
            outSample_q <= outSample_d;
        end
    end

    // Coefficient file: reset to pass-through, writable only while the MAC is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coef_q[0] <= COEF_UNITY;
            for (int i = 1; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coefWrite) begin
            coef_q[coef_addr[IDX_W-1:0]] <= coef_data;
        end
    end

    assign out_sample = outSample_q;
    assign out_valid  = outValid_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule
